// File: rtl/servant_uart_loader.sv
// servant_uart_loader: receives a length-prefixed program image over 8N1 UART and writes it into servant RAM over Wishbone
module servant_uart_loader #(
    parameter int          CLKS_PER_BIT = 868,
    parameter logic [31:0] BASE_ADR     = 32'h0000_0000,
    parameter int          MEM_WORDS    = 10048
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_rx,
    output logic        o_cpu_rst,
    output logic [31:0] o_wb_adr,
    output logic [31:0] o_wb_dat,
    output logic [3:0]  o_wb_sel,
    output logic        o_wb_we,
    output logic        o_wb_cyc,
    input  logic        i_wb_ack,
    output logic        o_done,
    output logic        o_err
);

    localparam int             CW        = $clog2(CLKS_PER_BIT + 1);
    localparam logic [CW-1:0]  HALF      = CW'(CLKS_PER_BIT / 2);
    localparam logic [CW-1:0]  FULL      = CW'(CLKS_PER_BIT - 1);
    localparam logic [31:0]    MAX_WORDS = 32'(MEM_WORDS);

    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
    typedef enum logic [2:0] {HDR0, HDR1, LOAD, WRITE, DONE, ERROR} ld_state_t;

    rx_state_t     rx_state;
    ld_state_t     ld_state;
    logic          rx_meta, rx_sync;
    logic [CW-1:0] cnt;
    logic [2:0]    bit_idx;
    logic [7:0]    shreg;
    logic          byte_valid, frame_err;
    logic [7:0]    n_lo;
    logic [15:0]   n_words, wcnt;
    logic [1:0]    bidx;
    logic [23:0]   word;
    logic [31:0]   hdr;

    assign o_wb_sel = 4'hF;
    assign hdr      = {16'd0, shreg, n_lo};

    // Two-flop synchroniser for the asynchronous RX line
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            rx_meta <= 1'b1;
            rx_sync <= 1'b1;
        end else begin
            rx_meta <= i_rx;
            rx_sync <= rx_meta;
        end
    end

    // UART receiver: mid-bit sampling, one-cycle byte_valid / frame_err pulses
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            rx_state   <= RX_IDLE;
            cnt        <= '0;
            bit_idx    <= '0;
            shreg      <= '0;
            byte_valid <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            byte_valid <= 1'b0;
            frame_err  <= 1'b0;
            case (rx_state)
                RX_IDLE: begin
                    if (!rx_sync) begin
                        rx_state <= RX_START;
                        cnt      <= HALF;
                    end
                end
                RX_START: begin
                    if (cnt != '0) begin
                        cnt <= cnt - CW'(1);
                    end else if (rx_sync) begin
                        rx_state <= RX_IDLE;
                    end else begin
                        rx_state <= RX_DATA;
                        cnt      <= FULL;
                        bit_idx  <= '0;
                    end
                end
                RX_DATA: begin
                    if (cnt != '0) begin
                        cnt <= cnt - CW'(1);
                    end else begin
                        shreg   <= {rx_sync, shreg[7:1]};
                        cnt     <= FULL;
                        bit_idx <= bit_idx + 3'd1;
                        if (bit_idx == 3'd7) rx_state <= RX_STOP;
                    end
                end
                default: begin
                    if (cnt != '0) begin
                        cnt <= cnt - CW'(1);
                    end else begin
                        byte_valid <= rx_sync;
                        frame_err  <= !rx_sync;
                        rx_state   <= RX_IDLE;
                    end
                end
            endcase
        end
    end

    // Image loader: header, word assembly, Wishbone writes, release or lock up in error
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            ld_state  <= HDR0;
            n_lo      <= '0;
            n_words   <= '0;
            wcnt      <= '0;
            bidx      <= '0;
            word      <= '0;
            o_wb_adr  <= BASE_ADR;
            o_wb_dat  <= '0;
            o_wb_cyc  <= 1'b0;
            o_wb_we   <= 1'b0;
            o_cpu_rst <= 1'b1;
            o_done    <= 1'b0;
            o_err     <= 1'b0;
        end else if ((frame_err && ld_state != DONE && ld_state != ERROR) ||
                     (byte_valid && ld_state == WRITE)) begin
            ld_state <= ERROR;
            o_err    <= 1'b1;
            o_wb_cyc <= 1'b0;
            o_wb_we  <= 1'b0;
        end else begin
            case (ld_state)
                HDR0: begin
                    if (byte_valid) begin
                        n_lo     <= shreg;
                        ld_state <= HDR1;
                    end
                end
                HDR1: begin
                    if (byte_valid) begin
                        n_words <= hdr[15:0];
                        wcnt    <= '0;
                        bidx    <= '0;
                        if (hdr == 32'd0 || hdr > MAX_WORDS) begin
                            ld_state <= ERROR;
                            o_err    <= 1'b1;
                        end else begin
                            ld_state <= LOAD;
                        end
                    end
                end
                LOAD: begin
                    if (byte_valid) begin
                        bidx <= bidx + 2'd1;
                        if (bidx == 2'd3) begin
                            o_wb_dat <= {shreg, word};
                            o_wb_cyc <= 1'b1;
                            o_wb_we  <= 1'b1;
                            ld_state <= WRITE;
                        end else begin
                            word <= {shreg, word[23:8]};
                        end
                    end
                end
                WRITE: begin
                    if (i_wb_ack) begin
                        o_wb_cyc <= 1'b0;
                        o_wb_we  <= 1'b0;
                        o_wb_adr <= o_wb_adr + 32'd4;
                        wcnt     <= wcnt + 16'd1;
                        if (wcnt + 16'd1 == n_words) begin
                            ld_state  <= DONE;
                            o_done    <= 1'b1;
                            o_cpu_rst <= 1'b0;
                        end else begin
                            ld_state <= LOAD;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_servant_uart_loader.sv
// tb_servant_uart_loader: directed scenarios for the UART boot loader with a Wishbone slave model
module tb_servant_uart_loader;

    localparam int CPB = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        rx = 1'b1;
    logic        ack = 1'b0;
    logic        cpu_rst, wb_we, wb_cyc, done, err;
    logic [31:0] wb_adr, wb_dat;
    logic [3:0]  wb_sel;

    int          tests = 0;
    int          fails = 0;
    int          ack_delay = 0;
    int          wait_cnt = 0;
    int          nw = 0;
    int          stable_err = 0;
    bit          cyc_seen = 1'b0;
    logic [31:0] cap_adr, cap_dat;
    logic [31:0] wr_adr [8];
    logic [31:0] wr_dat [8];
    logic        ack_done [8];
    logic [7:0]  img [10] = '{8'h02, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12, 8'hEF, 8'hBE, 8'hAD, 8'hDE};

    servant_uart_loader #(.CLKS_PER_BIT(CPB)) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_rx(rx), .o_cpu_rst(cpu_rst),
        .o_wb_adr(wb_adr), .o_wb_dat(wb_dat), .o_wb_sel(wb_sel), .o_wb_we(wb_we),
        .o_wb_cyc(wb_cyc), .i_wb_ack(ack), .o_done(done), .o_err(err)
    );

    always #5 clk = ~clk;

    // Wishbone slave: acks after ack_delay wait cycles, logs writes, checks hold stability
    initial begin
        forever begin
            @(negedge clk);
            if (wb_cyc) cyc_seen = 1'b1;
            if (ack) begin
                ack = 1'b0;
                if (nw > 0 && nw <= 8) ack_done[nw-1] = done;
            end else if (wb_cyc) begin
                if (wait_cnt == 0) begin
                    cap_adr = wb_adr;
                    cap_dat = wb_dat;
                end else if (wb_adr !== cap_adr || wb_dat !== cap_dat || wb_we !== 1'b1) begin
                    stable_err++;
                end
                if (wait_cnt >= ack_delay) begin
                    ack = 1'b1;
                    if (nw < 8) begin
                        wr_adr[nw] = wb_adr;
                        wr_dat[nw] = wb_dat;
                    end
                    nw++;
                    wait_cnt = 0;
                end else begin
                    wait_cnt++;
                end
            end else begin
                wait_cnt = 0;
            end
        end
    end

    task automatic do_reset();
        rst_n = 1'b0;
        rx = 1'b1;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        nw = 0;
        cyc_seen = 1'b0;
        stable_err = 0;
        repeat (4) @(negedge clk);
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop);
        rx = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            repeat (CPB) @(negedge clk);
        end
        rx = stop;
        repeat (CPB) @(negedge clk);
        rx = 1'b1;
        repeat (CPB) @(negedge clk);
    endtask

    task automatic send_img();
        for (int i = 0; i < 10; i++) send_byte(img[i], 1'b1);
    endtask

    task automatic wait_end(input string name);
        int k;
        k = 0;
        while (!done && !err && k < 300) begin
            @(negedge clk);
            k++;
        end
        tests++;
        if (k >= 300) begin
            fails++;
            $display("FAIL %s timeout: done=%b err=%b after %0d cycles, required done or err", name, done, err, k);
        end
        repeat (2) @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        tests += 6;
        if (cpu_rst !== 1'b1) begin fails++; $display("FAIL reset cpu_rst=%b want 1", cpu_rst); end
        if (wb_cyc !== 1'b0 || wb_we !== 1'b0) begin fails++; $display("FAIL reset cyc/we=%b%b want 00", wb_cyc, wb_we); end
        if (wb_adr !== 32'h0) begin fails++; $display("FAIL reset adr=%h want 0", wb_adr); end
        if (wb_dat !== 32'h0) begin fails++; $display("FAIL reset dat=%h want 0", wb_dat); end
        if (done !== 1'b0 || err !== 1'b0) begin fails++; $display("FAIL reset done/err=%b%b want 00", done, err); end
        if (wb_sel !== 4'hF) begin fails++; $display("FAIL reset sel=%h want f", wb_sel); end
    endtask

    task automatic test_basic();
        ack_delay = 0;
        do_reset();
        send_img();
        wait_end("basic");
        tests += 8;
        if (done !== 1'b1 || err !== 1'b0) begin fails++; $display("FAIL basic done/err=%b%b want 10", done, err); end
        if (cpu_rst !== 1'b0) begin fails++; $display("FAIL basic cpu_rst=%b want 0", cpu_rst); end
        if (nw !== 2) begin fails++; $display("FAIL basic writes=%0d want 2", nw); end
        if (wr_adr[0] !== 32'h0 || wr_dat[0] !== 32'h12345678) begin fails++; $display("FAIL basic w0 %h@%h want 12345678@0", wr_dat[0], wr_adr[0]); end
        if (wr_adr[1] !== 32'h4 || wr_dat[1] !== 32'hDEADBEEF) begin fails++; $display("FAIL basic w1 %h@%h want deadbeef@4", wr_dat[1], wr_adr[1]); end
        if (ack_done[0] !== 1'b0) begin fails++; $display("FAIL basic done_after_ack0=%b want 0", ack_done[0]); end
        if (ack_done[1] !== 1'b1) begin fails++; $display("FAIL basic done_on_ack1=%b want 1", ack_done[1]); end
        if (wb_adr !== 32'h8) begin fails++; $display("FAIL basic final adr=%h want 8", wb_adr); end
        send_byte(8'h55, 1'b0);
        tests += 2;
        if (done !== 1'b1 || err !== 1'b0) begin fails++; $display("FAIL after_done done/err=%b%b want 10", done, err); end
        if (nw !== 2) begin fails++; $display("FAIL after_done writes=%0d want 2", nw); end
    endtask

    task automatic test_wait_states();
        ack_delay = 5;
        do_reset();
        send_img();
        wait_end("wait");
        tests += 5;
        if (done !== 1'b1 || err !== 1'b0 || cpu_rst !== 1'b0) begin fails++; $display("FAIL wait done/err/cpu_rst=%b%b%b want 100", done, err, cpu_rst); end
        if (stable_err !== 0) begin fails++; $display("FAIL wait unstable_cycles=%0d want 0", stable_err); end
        if (nw !== 2) begin fails++; $display("FAIL wait writes=%0d want 2", nw); end
        if (wr_dat[0] !== 32'h12345678 || wr_dat[1] !== 32'hDEADBEEF) begin fails++; $display("FAIL wait data %h %h want 12345678 deadbeef", wr_dat[0], wr_dat[1]); end
        if (ack_done[1] !== 1'b1) begin fails++; $display("FAIL wait done_on_ack1=%b want 1", ack_done[1]); end
    endtask

    task automatic test_bad_header();
        ack_delay = 0;
        do_reset();
        send_byte(8'h00, 1'b1);
        send_byte(8'h00, 1'b1);
        repeat (4) @(negedge clk);
        tests += 3;
        if (err !== 1'b1 || done !== 1'b0) begin fails++; $display("FAIL hdr_zero err/done=%b%b want 10", err, done); end
        if (cyc_seen !== 1'b0) begin fails++; $display("FAIL hdr_zero cyc_seen=%b want 0", cyc_seen); end
        if (cpu_rst !== 1'b1) begin fails++; $display("FAIL hdr_zero cpu_rst=%b want 1", cpu_rst); end
        do_reset();
        send_byte(8'h41, 1'b1);
        send_byte(8'h27, 1'b1);
        send_img();
        tests += 3;
        if (err !== 1'b1 || done !== 1'b0) begin fails++; $display("FAIL hdr_big err/done=%b%b want 10", err, done); end
        if (cyc_seen !== 1'b0) begin fails++; $display("FAIL hdr_big cyc_seen=%b want 0", cyc_seen); end
        if (cpu_rst !== 1'b1) begin fails++; $display("FAIL hdr_big cpu_rst=%b want 1", cpu_rst); end
    endtask

    task automatic test_frame_err();
        ack_delay = 0;
        do_reset();
        send_byte(8'h02, 1'b1);
        send_byte(8'h00, 1'b1);
        send_byte(8'h78, 1'b1);
        send_byte(8'h56, 1'b0);
        send_byte(8'h34, 1'b1);
        send_byte(8'h12, 1'b1);
        tests += 3;
        if (err !== 1'b1) begin fails++; $display("FAIL frame err=%b want 1", err); end
        if (done !== 1'b0 || cpu_rst !== 1'b1) begin fails++; $display("FAIL frame done/cpu_rst=%b%b want 01", done, cpu_rst); end
        if (nw !== 0 || cyc_seen !== 1'b0) begin fails++; $display("FAIL frame writes=%0d cyc_seen=%b want 0 0", nw, cyc_seen); end
    endtask

    task automatic test_glitch();
        ack_delay = 0;
        do_reset();
        rx = 1'b0;
        @(negedge clk);
        rx = 1'b1;
        repeat (20) @(negedge clk);
        tests++;
        if (err !== 1'b0 || cyc_seen !== 1'b0) begin fails++; $display("FAIL glitch err=%b cyc_seen=%b want 0 0", err, cyc_seen); end
        send_img();
        wait_end("glitch");
        tests += 2;
        if (done !== 1'b1 || err !== 1'b0) begin fails++; $display("FAIL glitch_load done/err=%b%b want 10", done, err); end
        if (nw !== 2 || wr_dat[1] !== 32'hDEADBEEF || wr_adr[1] !== 32'h4) begin fails++; $display("FAIL glitch_load writes=%0d w1=%h@%h want 2 deadbeef@4", nw, wr_dat[1], wr_adr[1]); end
    endtask

    task automatic test_reset_midload();
        int k;
        ack_delay = 30;
        do_reset();
        send_img();
        k = 0;
        while (!wb_cyc && k < 100) begin
            @(negedge clk);
            k++;
        end
        tests += 2;
        if (!wb_cyc) begin fails++; $display("FAIL midload no second write cycle within %0d cycles", k); end
        if (nw !== 1) begin fails++; $display("FAIL midload writes_before_reset=%0d want 1", nw); end
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        tests += 2;
        if (wb_cyc !== 1'b0 || cpu_rst !== 1'b1) begin fails++; $display("FAIL midload cyc/cpu_rst=%b%b want 01", wb_cyc, cpu_rst); end
        if (wb_adr !== 32'h0) begin fails++; $display("FAIL midload adr=%h want 0", wb_adr); end
        @(negedge clk);
        rst_n = 1'b1;
        ack_delay = 0;
        nw = 0;
        repeat (4) @(negedge clk);
        send_img();
        wait_end("resend");
        tests += 2;
        if (done !== 1'b1 || err !== 1'b0) begin fails++; $display("FAIL resend done/err=%b%b want 10", done, err); end
        if (nw !== 2 || wr_dat[0] !== 32'h12345678 || wr_adr[0] !== 32'h0) begin fails++; $display("FAIL resend writes=%0d w0=%h@%h want 2 12345678@0", nw, wr_dat[0], wr_adr[0]); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_wait_states();
        test_bad_header();
        test_frame_err();
        test_glitch();
        test_reset_midload();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
